// File: rtl/cappp_pkg.sv
// cappp_pkg: shared definitions for the tag/response stage of the associative
// cell array.
//   - OP_* : 3-bit tag-command opcodes issued by the array controller
//   - cnt_state_e : responder-count sequencer states
package cappp_pkg;

   localparam logic [2:0] OP_SET_ALL   = 3'd0;
   localparam logic [2:0] OP_CLR_ALL   = 3'd1;
   localparam logic [2:0] OP_SEARCH    = 3'd2;
   localparam logic [2:0] OP_SEL_FIRST = 3'd3;
   localparam logic [2:0] OP_STEP      = 3'd4;
   localparam logic [2:0] OP_COUNT     = 3'd5;
   localparam logic [2:0] OP_INVERT    = 3'd6;
   localparam logic [2:0] OP_NOP       = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COUNTING = 2'd1,
      ST_DONE     = 2'd2
   } cnt_state_e;

endpackage

// File: rtl/lowest_set_isolate.sv
// lowest_set_isolate: finds the lowest set bit of a vector.
// Ports:
//   vec_i    in  WIDTH   vector to scan
//   onehot_o out WIDTH   only the lowest set bit of vec_i (all zero if none)
//   index_o  out IDX_W   position of the lowest set bit; WIDTH when none set
module lowest_set_isolate #(
   parameter int unsigned WIDTH = 100,
   parameter int unsigned IDX_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [WIDTH-1:0] onehot_o,
   output logic [IDX_W-1:0] index_o
);

   // Two's-complement trick: v & -v keeps only the lowest set bit.
   assign onehot_o = vec_i & (~vec_i + 1'b1);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      index_o = IDX_W'(WIDTH);
      for (int unsigned i = WIDTH; i > 0; i--) begin
         if (vec_i[i-1]) index_o = IDX_W'(i - 1);
      end
   end

endmodule

// File: rtl/tag_responder_unit.sv
// tag_responder_unit: tag register and response logic beside the associative
// cell array. Executes tag commands and reports responder status.
// Ports:
//   CLK, RST     clock (posedge) and asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op   command handshake and opcode
//   match_lines  per-cell mismatch from the array (1 = mismatch)
//   tags         tag register driving the array
//   some_none    at least one tag set
//   first_index  lowest set tag index, num_cells when none
//   resp_valid   one-cycle pulse, resp_count is fresh
//   resp_count   number of set tags captured at COUNT issue
module tag_responder_unit
   import cappp_pkg::*;
#(
   parameter int unsigned num_cells   = 100,
   parameter int unsigned chunk_width = 10,
   localparam int unsigned idx_w      = $clog2(num_cells + 1)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [num_cells-1:0] match_lines,
   output logic [num_cells-1:0] tags,
   output logic                 some_none,
   output logic [idx_w-1:0]     first_index,
   output logic                 resp_valid,
   output logic [idx_w-1:0]     resp_count
);

   localparam int unsigned NCHUNKS = (num_cells + chunk_width - 1) / chunk_width;
   localparam int unsigned PAD_W   = NCHUNKS * chunk_width;
   localparam int unsigned PTR_W   = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NCHUNKS - 1);

   cnt_state_e             state_q, state_d;
   logic [num_cells-1:0]   tags_q, tags_d;
   // Shadow is padded to whole chunks; pad bits stay zero so a partial
   // last chunk counts only real cells.
   logic [PAD_W-1:0]       shadow_q, shadow_d;
   logic [idx_w-1:0]       acc_q, acc_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [idx_w-1:0]       rcount_q, rcount_d;

   logic [num_cells-1:0]   low_onehot;
   logic [chunk_width-1:0] chunk;
   logic [idx_w-1:0]       chunk_pop;

   lowest_set_isolate #(
      .WIDTH (num_cells),
      .IDX_W (idx_w)
   ) u_lsi (
      .vec_i    (tags_q),
      .onehot_o (low_onehot),
      .index_o  (first_index)
   );

   always_comb begin
      chunk     = shadow_q[int'(ptr_q) * chunk_width +: chunk_width];
      chunk_pop = '0;
      for (int unsigned i = 0; i < chunk_width; i++) begin
         chunk_pop = chunk_pop + idx_w'(chunk[i]);
      end
   end

   always_comb begin
      state_d  = state_q;
      tags_d   = tags_q;
      shadow_d = shadow_q;
      acc_d    = acc_q;
      ptr_d    = ptr_q;
      rcount_d = rcount_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_SET_ALL:   tags_d = '1;
                  OP_CLR_ALL:   tags_d = '0;
                  OP_SEARCH:    tags_d = tags_q & ~match_lines;
                  OP_SEL_FIRST: tags_d = low_onehot;
                  OP_STEP:      tags_d = tags_q & ~low_onehot;
                  OP_COUNT: begin
                     shadow_d = PAD_W'(tags_q);
                     acc_d    = '0;
                     ptr_d    = '0;
                     state_d  = ST_COUNTING;
                  end
                  OP_INVERT:    tags_d = ~tags_q;
                  default:      tags_d = tags_q;
               endcase
            end
         end
         ST_COUNTING: begin
            acc_d = acc_q + chunk_pop;
            ptr_d = ptr_q + 1'b1;
            // Result is latched on the final chunk so it is already valid
            // during the DONE cycle.
            if (ptr_q == LAST_PTR) begin
               state_d  = ST_DONE;
               rcount_d = acc_d;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         tags_q   <= '0;
         shadow_q <= '0;
         acc_q    <= '0;
         ptr_q    <= '0;
         rcount_q <= '0;
      end else begin
         state_q  <= state_d;
         tags_q   <= tags_d;
         shadow_q <= shadow_d;
         acc_q    <= acc_d;
         ptr_q    <= ptr_d;
         rcount_q <= rcount_d;
      end
   end

   assign tags       = tags_q;
   assign some_none  = |tags_q;
   assign cmd_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_DONE);
   assign resp_count = rcount_q;

endmodule
